// File: rtl/afu_stream_pkg.sv
// Shared types and widths for the AFU streaming controller.
// Imported by afu_stream_ctrl and afu_wr_skid.
package afu_stream_pkg;

    localparam int LINE_WIDTH = 512;
    localparam int CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/afu_wr_skid.sv
// Two-entry skid buffer between the user output FIFO and the write-request port.
// A push and a pop in the same cycle leave the occupancy unchanged; entries leave in arrival order.
module afu_wr_skid
    import afu_stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid,
    input  logic [LINE_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [LINE_WIDTH-1:0] head_data,
    output logic                  not_empty,
    output logic [1:0]            occupancy
);

    logic [LINE_WIDTH-1:0] mem_reg [2];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && (count_reg != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_valid && ((count_reg != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign not_empty = (count_reg != 2'd0);
    assign occupancy = count_reg;

endmodule

// File: rtl/afu_stream_ctrl.sv
// Streams a job of ctx_length lines: reads feed the user input FIFO, the user output FIFO drains to writes.
// Define AFU_STREAM_PERF_EN to enable the read/write stall counters on perf_rd_stall / perf_wr_stall.
module afu_stream_ctrl
    import afu_stream_pkg::*;
#(
    parameter int BUFF_DEPTH_BITS = 3,
    parameter int MAX_OUTSTANDING = 2
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ctx_start,
    input  logic [CNT_WIDTH-1:0]  ctx_length,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [CNT_WIDTH-1:0]  rd_req_addr,
    input  logic                  rd_rsp_valid,
    input  logic [LINE_WIDTH-1:0] rd_rsp_data,
    output logic [LINE_WIDTH-1:0] input_fifo_din,
    output logic                  input_fifo_we,
    input  logic                  input_fifo_almost_full,
    output logic                  output_fifo_re,
    input  logic [LINE_WIDTH-1:0] output_fifo_dout,
    input  logic                  output_fifo_empty,
    output logic                  wr_req_valid,
    input  logic                  wr_req_ready,
    output logic [CNT_WIDTH-1:0]  wr_req_addr,
    output logic [LINE_WIDTH-1:0] wr_req_data,
    output logic                  ctx_busy,
    output logic                  ctx_done,
    output logic [CNT_WIDTH-1:0]  perf_rd_stall,
    output logic [CNT_WIDTH-1:0]  perf_wr_stall
);

    // Never allow more reads in flight than the input FIFO can absorb beyond its almost-full mark.
    localparam int FIFO_HEADROOM = (1 << BUFF_DEPTH_BITS) - 4;
    localparam int OUT_LIMIT_INT = (MAX_OUTSTANDING < FIFO_HEADROOM) ? MAX_OUTSTANDING : FIFO_HEADROOM;
    localparam logic [CNT_WIDTH-1:0] OUT_LIMIT = CNT_WIDTH'(OUT_LIMIT_INT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t                 state_reg;
    logic [CNT_WIDTH-1:0]   length_reg;
    logic [CNT_WIDTH-1:0]   rd_issued_reg;
    logic [CNT_WIDTH-1:0]   rd_outstanding_reg;
    logic [CNT_WIDTH-1:0]   wr_done_reg;
    logic                   ctx_busy_reg;
    logic                   ctx_done_reg;
    logic                   pop_inflight_reg;

    logic                   rd_fire;
    logic                   wr_fire;
    logic                   rsp_dec;
    logic                   active;
    logic [2:0]             skid_fill;
    logic [2:0]             skid_level;
    logic [CNT_WIDTH-1:0]   remaining;
    logic [1:0]             skid_occ;
    logic                   skid_not_empty;
    logic [LINE_WIDTH-1:0]  skid_head;

    assign active  = (state_reg == READ) || (state_reg == DRAIN);
    assign rd_fire = rd_req_valid && rd_req_ready;
    assign wr_fire = wr_req_valid && wr_req_ready;
    // Responses arriving after an abort are not counted against the next job.
    assign rsp_dec = rd_rsp_valid && (rd_outstanding_reg != '0);

    always_comb begin
        rd_req_valid   = 1'b0;
        output_fifo_re = 1'b0;
        skid_fill      = {1'b0, skid_occ} + {2'b00, pop_inflight_reg};
        // Occupancy after this cycle's write leaves; counting the departing head keeps 1 line/cycle.
        skid_level     = skid_fill - {2'b00, wr_fire};
        remaining      = length_reg - wr_done_reg;
        if (state_reg == READ) begin
            rd_req_valid = (rd_issued_reg < length_reg) && (rd_outstanding_reg < OUT_LIMIT)
                           && !input_fifo_almost_full;
        end
        // Never pop more lines than the job still has to write.
        if (active && !output_fifo_empty && (skid_level < 3'd2)
            && ({{(CNT_WIDTH-3){1'b0}}, skid_fill} < remaining)) begin
            output_fifo_re = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            length_reg         <= '0;
            rd_issued_reg      <= '0;
            rd_outstanding_reg <= '0;
            wr_done_reg        <= '0;
            ctx_busy_reg       <= 1'b0;
            ctx_done_reg       <= 1'b0;
            pop_inflight_reg   <= 1'b0;
        end else begin
            ctx_done_reg     <= 1'b0;
            pop_inflight_reg <= output_fifo_re;
            if (rd_fire) begin
                rd_issued_reg <= rd_issued_reg + CNT_ONE;
            end
            if (wr_fire) begin
                wr_done_reg <= wr_done_reg + CNT_ONE;
            end
            if (rd_fire && !rsp_dec) begin
                rd_outstanding_reg <= rd_outstanding_reg + CNT_ONE;
            end else if (!rd_fire && rsp_dec) begin
                rd_outstanding_reg <= rd_outstanding_reg - CNT_ONE;
            end
            case (state_reg)
                IDLE: begin
                    if (ctx_start) begin
                        length_reg         <= ctx_length;
                        rd_issued_reg      <= '0;
                        rd_outstanding_reg <= '0;
                        wr_done_reg        <= '0;
                        ctx_busy_reg       <= 1'b1;
                        if (ctx_length == '0) begin
                            state_reg    <= DONE;
                            ctx_done_reg <= 1'b1;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ, DRAIN: begin
                    if (wr_fire && ((wr_done_reg + CNT_ONE) == length_reg)) begin
                        state_reg    <= DONE;
                        ctx_done_reg <= 1'b1;
                    end else if ((state_reg == READ) && rd_fire
                                 && ((rd_issued_reg + CNT_ONE) == length_reg)) begin
                        state_reg <= DRAIN;
                    end
                end
                DONE: begin
                    state_reg    <= IDLE;
                    ctx_busy_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    afu_wr_skid u_wr_skid (
        .clk        (clk),
        .reset      (reset),
        .push_valid (pop_inflight_reg),
        .push_data  (output_fifo_dout),
        .pop        (wr_fire),
        .head_data  (skid_head),
        .not_empty  (skid_not_empty),
        .occupancy  (skid_occ)
    );

    assign input_fifo_we  = rd_rsp_valid;
    assign input_fifo_din = rd_rsp_data;
    assign rd_req_addr    = rd_issued_reg;
    assign wr_req_valid   = skid_not_empty;
    assign wr_req_data    = skid_head;
    assign wr_req_addr    = wr_done_reg;
    assign ctx_busy       = ctx_busy_reg;
    assign ctx_done       = ctx_done_reg;

`ifdef AFU_STREAM_PERF_EN
    logic [CNT_WIDTH-1:0] perf_rd_stall_reg;
    logic [CNT_WIDTH-1:0] perf_wr_stall_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_rd_stall_reg <= '0;
            perf_wr_stall_reg <= '0;
        end else if ((state_reg == IDLE) && ctx_start) begin
            perf_rd_stall_reg <= '0;
            perf_wr_stall_reg <= '0;
        end else begin
            if ((state_reg == READ) && input_fifo_almost_full && (perf_rd_stall_reg != '1)) begin
                perf_rd_stall_reg <= perf_rd_stall_reg + CNT_ONE;
            end
            if (wr_req_valid && !wr_req_ready && (perf_wr_stall_reg != '1)) begin
                perf_wr_stall_reg <= perf_wr_stall_reg + CNT_ONE;
            end
        end
    end

    assign perf_rd_stall = perf_rd_stall_reg;
    assign perf_wr_stall = perf_wr_stall_reg;
`else
    assign perf_rd_stall = '0;
    assign perf_wr_stall = '0;
`endif

endmodule
